// File: rtl/digest_piso.sv
// digest_piso: serialises a 256-bit digest to a byte-wide UART transmitter.
// Bytes go out big-endian. Each byte is handed over with a one-cycle tx_dv
// strobe, and the block then waits for tx_done before sending the next byte.
// Build option HEX_ASCII_EN: when defined, the block sends 64 lowercase hex
// characters followed by a carriage return (8'h0D). When undefined, it sends
// 32 raw bytes.
module digest_piso (
  input  logic         clk,
  input  logic         rst,
  input  logic         digest_valid,
  input  logic [255:0] digest,
  input  logic         tx_done,
  output logic         tx_dv,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic         done
);

`ifdef HEX_ASCII_EN
  localparam logic [6:0] TOTAL = 7'd65;
`else
  localparam logic [6:0] TOTAL = 7'd32;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [255:0]   r_shift;
  logic [6:0]     r_cnt;
  logic           w_capture;
  logic           w_advance;
  logic [7:0]     w_char;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic plus the capture and advance strobes for the datapath
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (digest_valid) begin
          w_capture = 1'b1;
          w_next    = SEND;
        end
      end
      SEND: w_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (r_cnt == TOTAL - 7'd1) begin
            w_next = FINISH;
          end else begin
            w_advance = 1'b1;
            w_next    = SEND;
          end
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift register and byte/character counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_shift <= digest;
      r_cnt   <= '0;
    end else if (w_advance) begin
      r_cnt <= r_cnt + 7'd1;
`ifdef HEX_ASCII_EN
      // Each byte produces two characters, so shift after the low nibble.
      if (r_cnt[0]) r_shift <= {r_shift[247:0], 8'h00};
`else
      r_shift <= {r_shift[247:0], 8'h00};
`endif
    end
  end

`ifdef HEX_ASCII_EN
  logic [3:0] w_nib;
  // Select the nibble for the current character and convert it to ASCII hex
  always_comb begin
    w_nib  = r_cnt[0] ? r_shift[251:248] : r_shift[255:252];
    w_char = (w_nib < 4'd10) ? ({4'h0, w_nib} + 8'h30) : ({4'h0, w_nib} + 8'h57);
    if (r_cnt == TOTAL - 7'd1) w_char = 8'h0D;
  end
`else
  assign w_char = r_shift[255:248];
`endif

  assign tx_dv   = (r_state == SEND);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FINISH);
  assign tx_byte = (r_state == IDLE) ? '0 : w_char;

endmodule

// File: doc/digest_piso.md
DIGEST_PISO -- requirements
Module: digest_piso

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: digest_valid  input  1  1-cycle strobe; digest is valid.
REQ-004 SHALL have port: digest  input  256  hash result; bits [255:248] are the first byte (big-endian byte order).
REQ-005 SHALL have port: tx_done  input  1  1-cycle strobe from UART transmitter: previous tx_byte fully sent.
REQ-006 SHALL have port: tx_dv  output  1  1-cycle strobe; tx_byte valid, start transmission.
REQ-007 SHALL have port: tx_byte  output  8  byte to transmit.
REQ-008 SHALL have port: busy  output  1  high from digest capture until done pulse, inclusive.
REQ-009 SHALL have port: done  output  1  1-cycle pulse after last byte's tx_done.

Function
REQ-010 SHALL implement FSM states IDLE, SEND, WAIT, FINISH.
REQ-011 IDLE: on digest_valid, SHALL capture digest into a 256-bit shift register, clear the byte counter, and go to SEND next cycle.
REQ-012 SEND: SHALL drive tx_dv=1 for exactly one cycle with the current byte/character on tx_byte, then go to WAIT.
REQ-013 First tx_dv SHALL occur in the cycle after the digest_valid capture edge (latency 1 cycle).
REQ-014 WAIT: SHALL hold tx_byte stable and stay in WAIT until tx_done=1.
REQ-015 On tx_done in WAIT: if more bytes remain, SHALL advance the shift register/counter and go to SEND. tx_dv for the next byte SHALL occur one cycle after the tx_done edge.
REQ-016 On tx_done in WAIT after the last byte, SHALL go to FINISH.
REQ-017 FINISH: SHALL assert done=1 for one cycle, then return to IDLE.
REQ-018 digest_valid in any state other than IDLE SHALL be ignored. There is no queuing and the held digest is not corrupted.
REQ-019 tx_done outside WAIT (including during the SEND cycle) SHALL be ignored.
REQ-020 busy SHALL be 1 in SEND, WAIT and FINISH, and 0 in IDLE.
REQ-021 tx_dv SHALL never be asserted in two consecutive cycles.
REQ-022 Byte counter SHALL be 7 bits wide and compare against the build-dependent total (32 or 65). There is no wrap past the total.
REQ-023 A digest_valid coinciding with the done cycle SHALL be ignored. A new capture is accepted only in IDLE.

Reset
REQ-024 rst=1 SHALL asynchronously force:
  - state=IDLE
  - tx_dv=0, tx_byte=8'h00, busy=0, done=0
  - shift register and counter to 0
REQ-025 rst asserted mid-transfer SHALL abort the transfer. No further tx_dv and no done pulse SHALL follow after release.
REQ-026 After rst deasserts, the block SHALL accept digest_valid on the first clk edge.

Configuration
REQ-027 Macro HEX_ASCII_EN SHALL select the output encoding.
REQ-028 HEX_ASCII_EN undefined: SHALL send 32 raw bytes, digest[255:248] first, with no terminator.
REQ-029 HEX_ASCII_EN defined: SHALL send 65 characters:
  - 64 lowercase ASCII hex characters, high nibble first ('0'-'9' = 8'h30-8'h39, 'a'-'f' = 8'h61-8'h66)
  - then a terminating 8'h0D
  - the shift register SHALL shift by 8 bits every second character.
REQ-030 All FSM, handshake and reset behaviour SHALL be identical in both builds; only tx_byte values and the total count differ.

Verification
Test digest D = SHA-256("abc") = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-031 Raw build: D strobed, bench returns tx_done 3 cycles after each tx_dv -> 32 tx_dv pulses; first tx_byte 8'hBA, second 8'h78, last 8'hAD; one done pulse; busy then low.
REQ-032 HEX_ASCII_EN build: D strobed -> 65 tx_dv pulses; characters 1-2 are 8'h62, 8'h61 ("ba"); character 64 is 8'h64 ('d'); character 65 is 8'h0D; then done.
REQ-033 Handshake timing: tx_done held off 50 cycles -> tx_byte stable, tx_dv low throughout; next tx_dv exactly 1 cycle after tx_done.
REQ-034 Ignored inputs:
  - second digest_valid (all-zero digest) after byte 5 -> remaining bytes still from D; one done pulse only
  - spurious tx_done in IDLE and SEND -> no effect.
REQ-035 rst asserted after byte 10 for 2 cycles -> all outputs 0 immediately; no done pulse. A new D strobe then yields a full 32-byte transfer starting with 8'hBA.
